// File: rtl/fetch_unit.sv
// Fetch stage: PC, imem read issue, 2-entry {pc,word} queue, field split.
// Ports: clk/rst_n (sync low), imem_*, redirect*, out_* handshake, halted,
// stall_cnt (live only when FETCH_STALL_CNT_EN is defined, else 0).
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]        HALT_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [23:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [7:0]        out_opcode,
  output logic [3:0]        out_rd,
  output logic [3:0]        out_rs1,
  output logic [3:0]        out_rs2,
  output logic [7:0]        out_imm8,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned EW = ADDR_W + 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rpc_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              hd_q, hd_d;
  logic              wr_q, wr_d;
  logic              infl_q;
  logic              sq_q;
  logic [EW-1:0]     ent_q [2];
  logic [EW-1:0]     head;

  logic              pop;
  logic              flush;
  logic              push;
  logic              fetch;
  logic [2:0]        occ;
  logic [2:0]        lim;

  assign head      = ent_q[hd_q];
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign flush     = redirect & (state_q != S_IDLE);
  // sq_q drops a response belonging to the pre-redirect stream
  assign push      = infl_q & ~sq_q & ~flush;
  // occupancy counts the in-flight word so the queue can never overflow
  assign occ       = {1'b0, cnt_q} + {2'b00, infl_q};
  assign lim       = 3'd2 + {2'b00, pop};
  assign fetch     = (state_q == S_RUN) & ~redirect & (occ < lim);

  assign imem_en    = fetch;
  assign imem_addr  = pc_q;
  assign out_instr  = head[23:0];
  assign out_pc     = head[EW-1:24];
  assign out_opcode = head[23:16];
  assign out_rd     = head[15:12];
  assign out_rs1    = head[11:8];
  assign out_rs2    = head[7:4];
  assign out_imm8   = head[7:0];
  assign halted     = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    hd_d    = hd_q;
    wr_d    = wr_q;
    if (fetch) pc_d = pc_q + ADDR_W'(1);
    if (flush) begin
      state_d = S_RUN;
      pc_d    = redirect_pc;
      cnt_d   = 2'd0;
      hd_d    = 1'b0;
      wr_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN: begin
          if (push && imem_rdata[23:16] == HALT_OP)
            state_d = S_HALT;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
      if (push) wr_d = ~wr_q;
      if (pop) hd_d = ~hd_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      rpc_q    <= '0;
      cnt_q    <= 2'd0;
      hd_q     <= 1'b0;
      wr_q     <= 1'b0;
      infl_q   <= 1'b0;
      sq_q     <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      hd_q    <= hd_d;
      wr_q    <= wr_d;
      infl_q  <= fetch;
      sq_q    <= flush;
      if (fetch) rpc_q <= pc_q;
      if (push) ent_q[wr_q] <= {rpc_q, imem_rdata};
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect/reset
// against a transaction-level model (timestamped issue queue).
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [23:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_instr;
  logic [15:0] out_pc;
  logic [7:0]  out_opcode;
  logic [3:0]  out_rd;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [7:0]  out_imm8;
  logic        halted;
  logic [15:0] stall_cnt;

  fetch_unit #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_imm8   (out_imm8),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [65536];

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
    else imem_rdata <= 24'($urandom);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] q_pc [$];
  int          q_t [$];
  logic [15:0] got_pc [$];
  logic [15:0] fpc_m;
  logic [15:0] stall_m;
  logic        run_m, halt_m, idle_m, hflag;
  int          cyc;

  function automatic logic [15:0] stall_e();
`ifdef FETCH_STALL_CNT_EN
    return stall_m;
`else
    return 16'd0;
`endif
  endfunction

  task automatic reset_model();
    q_pc.delete();
    q_t.delete();
    fpc_m   = 16'd0;
    stall_m = 16'd0;
    run_m   = 1'b0;
    halt_m  = 1'b0;
    idle_m  = 1'b1;
    hflag   = 1'b0;
  endtask

  task automatic step(input logic rdy, input logic rd,
                      input logic [15:0] rp, input logic rs);
    logic        ve, pe, ee;
    logic [23:0] w;
    @(negedge clk);
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rp;
    rst_n       = rs;
    #1;
    ve = (q_pc.size() > 0) && (q_t[0] <= cyc);
    pe = ve && rdy;
    ee = run_m && !rd && ((q_pc.size() - (pe ? 1 : 0)) < 2);
    check("valid", 32'(out_valid), 32'(ve));
    check("en", 32'(imem_en), 32'(ee));
    if (ee) check("addr", 32'(imem_addr), 32'(fpc_m));
    check("halted", 32'(halted), 32'(halt_m));
    check("stall", 32'(stall_cnt), 32'(stall_e()));
    if (out_valid && out_ready) got_pc.push_back(out_pc);
    if (pe) begin
      w = mem[q_pc[0]];
      check("pc", 32'(out_pc), 32'(q_pc[0]));
      check("instr", 32'(out_instr), 32'(w));
      check("opcode", 32'(out_opcode), 32'(w[23:16]));
      check("rd", 32'(out_rd), 32'(w[15:12]));
      check("rs1", 32'(out_rs1), 32'(w[11:8]));
      check("rs2", 32'(out_rs2), 32'(w[7:4]));
      check("imm8", 32'(out_imm8), 32'(w[7:0]));
      void'(q_pc.pop_front());
      void'(q_t.pop_front());
    end
    if (ve && !rdy && stall_m != 16'hFFFF) stall_m++;
    if (!rs) begin
      reset_model();
    end else if (rd && (run_m || halt_m)) begin
      q_pc.delete();
      q_t.delete();
      fpc_m  = rp;
      run_m  = 1'b1;
      halt_m = 1'b0;
      hflag  = 1'b0;
    end else begin
      if (idle_m) begin
        idle_m = 1'b0;
        run_m  = 1'b1;
      end
      if (hflag) begin
        run_m  = 1'b0;
        halt_m = 1'b1;
      end
      hflag = ee && (mem[fpc_m][23:16] == 8'hFF);
      if (ee) begin
        q_pc.push_back(fpc_m);
        q_t.push_back(cyc + 2);
        fpc_m++;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [23:0] w;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      w = 24'($urandom);
      if (w[23:16] == 8'hFF) w[23:16] = 8'h00;
      mem[i] = w;
    end
    for (int k = 0; k < 20; k++) begin
      a = 16'($urandom_range(16'h0200, 16'hFE00));
      mem[a][23:16] = 8'hFF;
    end
    mem[0] = 24'h123456;
    mem[5] = 24'hFF0505;

    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'd0;
    cyc = 0;
    repeat (2) @(posedge clk);
    reset_model();

    // reset state
    step(1'b1, 1'b0, 16'd0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_instr", 32'(out_instr), 32'd0);
    check("rst_pc", 32'(out_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // startup
    step(1'b1, 1'b0, 16'd0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("st_en", 32'(imem_en), 32'd1);
    check("st_addr", 32'(imem_addr), 32'd0);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("st_nv", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("st_v", 32'(out_valid), 32'd1);
    check("st_op", 32'(out_opcode), 32'h12);
    check("st_rd", 32'(out_rd), 32'd3);
    check("st_rs1", 32'(out_rs1), 32'd4);
    check("st_rs2", 32'(out_rs2), 32'd5);
    check("st_imm", 32'(out_imm8), 32'h56);
    check("st_pc0", 32'(out_pc), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 16'd0, 1'b1);
      check("st_seq", 32'(out_pc), 32'(i));
    end

    // halt at 5, drain, then resume at 0
    repeat (8) step(1'b1, 1'b0, 16'd0, 1'b1);
    check("h_halted", 32'(halted), 32'd1);
    check("h_en", 32'(imem_en), 32'd0);
    check("h_drained", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 16'd0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("h_resume", 32'(imem_en), 32'd1);
    check("h_res_addr", 32'(imem_addr), 32'd0);
    repeat (10) step(1'b1, 1'b0, 16'd0, 1'b1);

    // back-pressure then redirect with a full queue
    step(1'b1, 1'b1, 16'h0100, 1'b1);
    repeat (10) step(1'b0, 1'b0, 16'd0, 1'b1);
    check("bp_en", 32'(imem_en), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_pc", 32'(out_pc), 32'h0100);
    step(1'b0, 1'b1, 16'h0040, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("r1_en", 32'(imem_en), 32'd1);
    check("r1_addr", 32'(imem_addr), 32'h0040);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("r3_valid", 32'(out_valid), 32'd1);
    check("r3_pc", 32'(out_pc), 32'h0040);
    repeat (4) step(1'b1, 1'b0, 16'd0, 1'b1);

    // PC wrap
    step(1'b1, 1'b1, 16'hFFFE, 1'b1);
    got_pc.delete();
    repeat (6) step(1'b1, 1'b0, 16'd0, 1'b1);
    check("wrap_n", 32'(got_pc.size() >= 4), 32'd1);
    if (got_pc.size() >= 4) begin
      check("wrap0", 32'(got_pc[0]), 32'hFFFE);
      check("wrap1", 32'(got_pc[1]), 32'hFFFF);
      check("wrap2", 32'(got_pc[2]), 32'h0000);
      check("wrap3", 32'(got_pc[3]), 32'h0001);
    end

    // reset mid-stream with a full queue
    step(1'b1, 1'b1, 16'h0080, 1'b1);
    repeat (5) step(1'b0, 1'b0, 16'd0, 1'b1);
    check("mr_full", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 16'd0, 1'b0);
    step(1'b0, 1'b0, 16'd0, 1'b0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_en", 32'(imem_en), 32'd0);
    check("mr_stall", 32'(stall_cnt), 32'd0);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    step(1'b1, 1'b0, 16'd0, 1'b1);
    check("mr_en2", 32'(imem_en), 32'd1);
    check("mr_addr", 32'(imem_addr), 32'd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic        rdy, rd, rs;
      logic [15:0] rp;
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rp  = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      rs  = ($urandom_range(0, 499) != 0);
      step(rdy, rd, rp, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 24-bit RISC core. It owns the program counter, issues word reads to the synchronous instruction memory, and buffers returned words in a 2-entry queue. It presents each instruction, split into fields, to decode over a valid/ready handshake. Its `out_imm8` field feeds the 8-to-24-bit immediate sign-extender directly. Branch redirects from execute flush the stage, and a HALT opcode stops fetching.

## Interface
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_OP`, 8'hFF: opcode that stops fetching.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_en` out 1: read strobe. Data returns on `imem_rdata` exactly one cycle later.
- `imem_addr` out ADDR_W: read word address, equal to the current PC.
- `imem_rdata` in 24: read data, valid the cycle after `imem_en`.
- `redirect` in 1: branch/jump taken; flush and restart.
- `redirect_pc` in ADDR_W: restart address.
- `out_valid` out 1: head instruction available.
- `out_ready` in 1: decode accepts the head when `out_valid && out_ready`.
- `out_instr` out 24: raw instruction word.
- `out_pc` out ADDR_W: address of `out_instr`.
- `out_opcode` out 8: bits [23:16].
- `out_rd` out 4: bits [15:12].
- `out_rs1` out 4: bits [11:8].
- `out_rs2` out 4: bits [7:4].
- `out_imm8` out 8: bits [7:0]; goes to the sign-extender.
- `halted` out 1: fetch is stopped in state HALT.
- `stall_cnt` out 16: decode back-pressure cycle count (see Configuration).

## Operation
- States:
  - IDLE: reset state.
  - RUN: fetching.
  - HALT: fetch stopped.
- State transitions:
  - IDLE→RUN on the first clock edge with `rst_n` high.
  - RUN→HALT when a word with opcode `HALT_OP` is written into the queue.
  - HALT→RUN only on `redirect`.
  - `redirect` in IDLE is ignored.
- Queue and credit tracking:
  - Depth is 2, with `count` ∈ {0,1,2}.
  - `inflight` is set on the cycle after `imem_en` and means a response is arriving this cycle.
  - Issue rule: `imem_en = (state==RUN) && !redirect && (count + inflight − pop) < 2`, where `pop = out_valid && out_ready`.
  - The queue therefore never overflows, and the memory needs no back-pressure.
- PC update:
  - Each `imem_en` cycle: PC ← PC+1.
  - The PC wraps from 2^ADDR_W−1 to 0 with no flag.
  - Each queue entry stores `{pc, word}`.
- Response capture: when `inflight` is set and not squashed, the word is written to the queue tail in the same edge.
- Redirect, when `redirect` is high in RUN or HALT:
  - Highest priority.
  - At the edge: queue is emptied (`count`←0), PC ← `redirect_pc`, state ← RUN.
  - Any response arriving in that cycle or the next is discarded via a squash flag.
  - `imem_en` is 0 in the redirect cycle.
  - A pop that is coincident with redirect is still a valid handshake.
- HALT: no new fetches. Words already in the queue or in flight still drain to decode in order. `halted` = (state==HALT).
- Field outputs are pure slices of the queue head. They are meaningful only while `out_valid` is high.

## Timing
- Reset values (while `rst_n` low at an edge):
  - state IDLE, PC=`RESET_PC`, `count`=0, `inflight`=0.
  - `imem_en`=0, `out_valid`=0, `halted`=0, `stall_cnt`=0.
  - `out_*` data is 0.
- Reset mid-operation discards everything; there is no partial drain.
- Startup after reset release at edge E0:
  - Cycle after E0: `imem_en`=1 with `imem_addr`=`RESET_PC`.
  - Next edge: `imem_rdata` is captured.
  - `out_valid` rises 2 cycles after `imem_en`.
- Latency from `imem_en` to `out_valid` is 2 cycles.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- Redirect at edge R:
  - `imem_en`=1 at `redirect_pc` in cycle R+1.
  - First redirected instruction is valid at R+3.
  - `out_valid`=0 from R+1 to R+2.
- Boundaries:
  - Full queue with `out_ready`=0: `imem_en` stays 0, and the PC holds.
  - Queue full with one pop: one fetch is issued that cycle.
  - Empty queue: `out_valid`=0, and `out_ready` is ignored.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cnt` increments every cycle with `out_valid && !out_ready`.
  - It saturates at 16'hFFFF.
  - It clears only on reset.
- Not defined: `stall_cnt` is tied to 0, and no counter logic is built.

## Test plan
- Reset release, memory returns 24'h12_3456 at addr 0, `out_ready`=1 → `out_valid` 2 cycles after first `imem_en`; `out_opcode`=8'h12, `out_rd`=3, `out_rs1`=4, `out_rs2`=5, `out_imm8`=8'h56, `out_pc`=0; then PCs 1,2,3 appear on consecutive cycles.
- Hold `out_ready`=0 for 10 cycles → exactly 2 entries queued; `imem_en` stays low; no word lost or duplicated after release. With the macro defined, `stall_cnt` equals the number of back-pressured cycles with `out_valid`=1.
- `redirect`=1 to `redirect_pc`=16'h0040 while both entries and one response are in flight → none of the old words reach decode; next valid instruction has `out_pc`=16'h0040 at R+3.
- Word with opcode 8'hFF at addr 5 → `halted`=1; no `imem_en` after addr 6 issued; queued words drain; `redirect` to 0 resumes fetching.
- `ADDR_W`=4, run past PC 15 → `imem_addr` wraps to 0, and `out_pc` sequence is 14, 15, 0, 1.
- Pull `rst_n` low mid-stream with a full queue → next cycle `out_valid`=0, `imem_en`=0, `stall_cnt`=0; restart fetches `RESET_PC`.
